// File: rtl/spectrum_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dav_pkg: shared types and helpers for the spectrum frame controller.
//   spec_state_t  frame FSM state type
//   DEF_*         default widths / bin count used by the interface and modules
//   SAT_W         working width of the saturation helper
//   sat_u()       clamp an unsigned value to the largest value that fits in
//                 'width' bits
// -----------------------------------------------------------------------------
package dav_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_CAPTURE,
    ST_HOLD
  } spec_state_t;

  localparam int unsigned DEF_NUM_BINS = 16;
  localparam int unsigned DEF_FFT_W    = 36;
  localparam int unsigned DEF_BAR_W    = 18;
  localparam int unsigned SAT_W        = 64;

  function automatic logic [SAT_W-1:0] sat_u(input logic [SAT_W-1:0] value,
                                            input int unsigned       width);
    logic [SAT_W-1:0] lim;
    if (width >= SAT_W) return value;
    lim = (SAT_W'(1) << width) - SAT_W'(1);
    return (value > lim) ? lim : value;
  endfunction

endpackage

// File: rtl/spectrum_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// spectrum_frame_ctrl_if: frame-sync / FFT / bar-renderer signal bundle.
//   vsync        frame sync level from the VGA timing generator
//   fft_start    one-cycle FFT trigger
//   fft_done     FFT completion pulse/level
//   fft_bins     packed complex bins, bin k at [k*FFT_W +: FFT_W]
//   bars         packed bar heights, bar k at [k*BAR_W +: BAR_W]
//   bars_valid   one-cycle strobe after the last bar is updated
//   busy         controller is in START, WAIT or CAPTURE
//   timeout_err  sticky FFT timeout flag
// Modports: master = the controller, slave = its environment.
// -----------------------------------------------------------------------------
interface spectrum_frame_ctrl_if
  import dav_pkg::*;
#(
  parameter int unsigned NUM_BINS = DEF_NUM_BINS,
  parameter int unsigned FFT_W    = DEF_FFT_W,
  parameter int unsigned BAR_W    = DEF_BAR_W
) ();

  logic                      vsync;
  logic                      fft_start;
  logic                      fft_done;
  logic [NUM_BINS*FFT_W-1:0] fft_bins;
  logic [NUM_BINS*BAR_W-1:0] bars;
  logic                      bars_valid;
  logic                      busy;
  logic                      timeout_err;

  modport master (
    input  vsync, fft_done, fft_bins,
    output fft_start, bars, bars_valid, busy, timeout_err
  );

  modport slave (
    output vsync, fft_done, fft_bins,
    input  fft_start, bars, bars_valid, busy, timeout_err
  );

endinterface

// File: rtl/spectrum_frame_ctrl_bin_magnitude.sv
// -----------------------------------------------------------------------------
// bin_magnitude: combinational magnitude estimate of one packed complex bin.
//   bin_i  {re[H-1:0], im[H-1:0]}, both signed, H = FFT_W/2
//   bar_o  max(|re|,|im|) + min(|re|,|im|)/2, saturated to BAR_W bits
// The most-negative component maps to 2^(H-1)-1 so |x| always fits H-1 bits.
// -----------------------------------------------------------------------------
module bin_magnitude
  import dav_pkg::*;
#(
  parameter int unsigned FFT_W = DEF_FFT_W,
  parameter int unsigned BAR_W = DEF_BAR_W
) (
  input  logic [FFT_W-1:0] bin_i,
  output logic [BAR_W-1:0] bar_o
);

  localparam int unsigned   H        = FFT_W / 2;
  localparam logic [H-1:0]  MOST_NEG = {1'b1, {(H-1){1'b0}}};
  localparam logic [H-1:0]  MAX_POS  = {1'b0, {(H-1){1'b1}}};

  logic [H-1:0] re, im, a, b, hi, lo;
  logic [H:0]   mag;

  function automatic logic [H-1:0] abs_clip(input logic [H-1:0] x);
    if (x == MOST_NEG)  return MAX_POS;
    else if (x[H-1])    return -x;
    else                return x;
  endfunction

  always_comb begin
    re = bin_i[2*H-1:H];
    im = bin_i[H-1:0];
    a  = abs_clip(re);
    b  = abs_clip(im);
    if (a >= b) begin
      hi = a;
      lo = b;
    end else begin
      hi = b;
      lo = a;
    end
    mag   = {1'b0, hi} + {2'b00, lo[H-1:1]};
    bar_o = BAR_W'(sat_u(SAT_W'(mag), BAR_W));
  end

endmodule

// File: rtl/spectrum_frame_ctrl.sv
// -----------------------------------------------------------------------------
// spectrum_frame_ctrl: once per video frame, trigger the FFT, wait for it with
// a timeout, and turn each complex bin into a saturated bar height.
//   clk   pixel clock
//   rst   synchronous, active-high reset
//   bus   spectrum_frame_ctrl_if.master (vsync, fft_start, fft_done, fft_bins,
//         bars, bars_valid, busy, timeout_err)
// Build option: define SPECTRUM_PEAK_DECAY_EN for peak-hold with exponential
// decay (bar falls by bar >> DECAY_SHIFT per frame); otherwise bars follow the
// new magnitude directly and DECAY_SHIFT has no effect.
// -----------------------------------------------------------------------------
module spectrum_frame_ctrl
  import dav_pkg::*;
#(
  parameter int unsigned NUM_BINS    = DEF_NUM_BINS,
  parameter int unsigned FFT_W       = DEF_FFT_W,
  parameter int unsigned BAR_W       = DEF_BAR_W,
  parameter int unsigned DECAY_SHIFT = 3,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input logic                  clk,
  input logic                  rst,
  spectrum_frame_ctrl_if.master bus
);

  localparam int unsigned IDX_W = $clog2(NUM_BINS);
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  spec_state_t      state_q, state_d;
  logic             vsync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             timeout_q, timeout_d;
  logic             valid_q, valid_d;
  logic             bar_we;

  logic [BAR_W-1:0]          bars_q [NUM_BINS];
  logic [FFT_W-1:0]          bin_sel;
  logic [BAR_W-1:0]          mag;
  logic [BAR_W-1:0]          bar_new;
  logic [NUM_BINS*BAR_W-1:0] bars_flat;

  // One shared magnitude unit, time-multiplexed across bins during CAPTURE.
  assign bin_sel = bus.fft_bins[idx_q*FFT_W +: FFT_W];

  bin_magnitude #(
    .FFT_W (FFT_W),
    .BAR_W (BAR_W)
  ) u_mag (
    .bin_i (bin_sel),
    .bar_o (mag)
  );

`ifdef SPECTRUM_PEAK_DECAY_EN
  logic [BAR_W-1:0] old_bar, decayed;

  always_comb begin
    old_bar = bars_q[idx_q];
    decayed = old_bar - (old_bar >> DECAY_SHIFT);
    if (mag >= old_bar || mag >= decayed) bar_new = mag;
    else                                  bar_new = decayed;
  end
`else
  logic unused_decay_shift;
  assign unused_decay_shift = ^DECAY_SHIFT;

  always_comb begin
    bar_new = mag;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    timeout_d = timeout_q;
    valid_d   = 1'b0;
    bar_we    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.vsync && !vsync_q) state_d = ST_START;
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion arriving on the final counted cycle takes priority.
        if (bus.fft_done) begin
          idx_d   = '0;
          state_d = ST_CAPTURE;
        end else if (cnt_q == LAST_CNT) begin
          timeout_d = 1'b1;
          state_d   = ST_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        bar_we = 1'b1;
        if (idx_q == LAST_IDX) begin
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (!bus.vsync) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // vsync_q resets high so a vsync level held across reset release is not
  // mistaken for a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      vsync_q   <= 1'b1;
      cnt_q     <= '0;
      idx_q     <= '0;
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_BINS; i++) bars_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      vsync_q   <= bus.vsync;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
      valid_q   <= valid_d;
      if (bar_we) bars_q[idx_q] <= bar_new;
    end
  end

  always_comb begin
    bars_flat = '0;
    for (int unsigned i = 0; i < NUM_BINS; i++) bars_flat[i*BAR_W +: BAR_W] = bars_q[i];
  end

  assign bus.bars        = bars_flat;
  assign bus.fft_start   = (state_q == ST_START);
  assign bus.busy        = (state_q == ST_START) || (state_q == ST_WAIT) ||
                           (state_q == ST_CAPTURE);
  assign bus.bars_valid  = valid_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_spectrum_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spectrum_frame_ctrl: self-checking bench for spectrum_frame_ctrl.
// Frames are driven as a timeline of the documented cycle relationships; the
// driver keeps the expected outputs and bar model for each cycle, and one
// process compares every output on every falling edge.
// -----------------------------------------------------------------------------
module tb_spectrum_frame_ctrl;

  localparam int NB = 16;
  localparam int FW = 36;
  localparam int BW = 16;
  localparam int DS = 3;
  localparam int TO = 16;
  localparam int H  = FW / 2;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic chk_en = 1'b0;

  int total = 0;
  int bad   = 0;

  logic   exp_start   = 1'b0;
  logic   exp_busy    = 1'b0;
  logic   exp_valid   = 1'b0;
  logic   exp_timeout = 1'b0;
  longint mbars [NB];
  int     re_v  [NB];
  int     im_v  [NB];

  always #5 clk = ~clk;

  spectrum_frame_ctrl_if #(.NUM_BINS(NB), .FFT_W(FW), .BAR_W(BW)) bus ();

  spectrum_frame_ctrl #(
    .NUM_BINS    (NB),
    .FFT_W       (FW),
    .BAR_W       (BW),
    .DECAY_SHIFT (DS),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string nm, input logic [NB*BW-1:0] act,
                       input logic [NB*BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NB*BW-1:0] exp_bars();
    logic [NB*BW-1:0] r;
    r = '0;
    for (int k = 0; k < NB; k++) r[k*BW +: BW] = BW'(mbars[k]);
    return r;
  endfunction

  function automatic logic [BW-1:0] dut_bar(input int k);
    return bus.bars[k*BW +: BW];
  endfunction

  // Magnitude from the arithmetic definition, using wide integers.
  function automatic longint mag_model(input int re, input int im);
    longint a, b, hi, lo, m;
    longint most_neg = -(longint'(1) << (H - 1));
    longint lim      = (longint'(1) << BW) - 1;
    a  = (re < 0) ? ((re == most_neg) ? -most_neg - 1 : -longint'(re)) : longint'(re);
    b  = (im < 0) ? ((im == most_neg) ? -most_neg - 1 : -longint'(im)) : longint'(im);
    hi = (a > b) ? a : b;
    lo = (a > b) ? b : a;
    m  = hi + lo / 2;
    return (m > lim) ? lim : m;
  endfunction

  task automatic apply_bar(input int k);
    longint nv;
`ifdef SPECTRUM_PEAK_DECAY_EN
    longint dec;
`endif
    nv = mag_model(re_v[k], im_v[k]);
`ifdef SPECTRUM_PEAK_DECAY_EN
    dec = mbars[k] - (mbars[k] >> DS);
    if (nv >= mbars[k])  mbars[k] = nv;
    else                 mbars[k] = (nv > dec) ? nv : dec;
`else
    mbars[k] = nv;
`endif
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("fft_start",   bus.fft_start,   exp_start);
      check("busy",        bus.busy,        exp_busy);
      check("bars_valid",  bus.bars_valid,  exp_valid);
      check("timeout_err", bus.timeout_err, exp_timeout);
      check("bars",        bus.bars,        exp_bars());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    exp_start = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic set_bins();
    for (int k = 0; k < NB; k++)
      bus.fft_bins[k*FW +: FW] = {H'(re_v[k]), H'(im_v[k])};
  endtask

  task automatic clear_bins();
    for (int k = 0; k < NB; k++) begin
      re_v[k] = 0;
      im_v[k] = 0;
    end
  endtask

  function automatic int rnd_h();
    case ($urandom_range(0, 7))
      0:       return -(1 << (H - 1));
      1:       return (1 << (H - 1)) - 1;
      2:       return 0;
      default: return int'($urandom_range(0, (1 << H) - 1)) - (1 << (H - 1));
    endcase
  endfunction

  task automatic idle_gap(input bit noisy);
    int n;
    n = int'($urandom_range(1, 4));
    repeat (n) begin
      tick();
      bus.vsync    = 1'b0;
      bus.fft_done = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  // Entered in IDLE with vsync low on the previous cycle. delay is the WAIT
  // cycle index carrying fft_done (>= TO means it never comes). rst_at >= 0
  // resets the DUT during that capture cycle.
  task automatic run_frame(input int delay, input bit noisy, input int rst_at);
    bit timed_out;
    timed_out = 1'b1;
    tick();
    bus.vsync    = 1'b1;
    bus.fft_done = 1'b0;
    tick();
    exp_start = 1'b1;
    exp_busy  = 1'b1;
    for (int w = 0; w < TO; w++) begin
      tick();
      if (noisy) bus.vsync = 1'($urandom_range(0, 1));
      bus.fft_done = (w == delay);
      if (w == delay) begin
        timed_out = 1'b0;
        break;
      end
    end
    if (timed_out) begin
      tick();
      bus.fft_done = 1'b0;
      bus.vsync    = 1'b1;
      exp_busy     = 1'b0;
      exp_timeout  = 1'b1;
    end else begin
      for (int k = 0; k < NB; k++) begin
        tick();
        bus.fft_done = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noisy) bus.vsync = 1'($urandom_range(0, 1));
        if (k > 0) apply_bar(k - 1);
        if (k == rst_at) begin
          rst = 1'b1;
          tick();
          rst          = 1'b0;
          bus.vsync    = 1'b0;
          bus.fft_done = 1'b0;
          exp_busy     = 1'b0;
          exp_timeout  = 1'b0;
          for (int j = 0; j < NB; j++) mbars[j] = 0;
          return;
        end
      end
      tick();
      bus.fft_done = 1'b0;
      bus.vsync    = 1'b1;
      apply_bar(NB - 1);
      exp_valid = 1'b1;
      exp_busy  = 1'b0;
    end
    repeat ($urandom_range(0, 3)) tick();
    tick();
    bus.vsync = 1'b0;
  endtask

  initial begin
    bus.vsync    = 1'b1;
    bus.fft_done = 1'b0;
    bus.fft_bins = '0;
    clear_bins();
    for (int k = 0; k < NB; k++) mbars[k] = 0;

    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    // vsync held high through reset release must not start a frame
    repeat (4) tick();
    check("no_trigger_busy", bus.busy, 1'b0);
    tick();
    bus.vsync = 1'b0;
    idle_gap(1'b0);

    // re=100, im=-40 -> 100 + 40/2 = 120
    clear_bins();
    re_v[0] = 100;
    im_v[0] = -40;
    set_bins();
    run_frame(9, 1'b0, -1);
    check("lit_bar0",   dut_bar(0), 120);
    check("model_bar0", mbars[0],   120);
    idle_gap(1'b0);

    // most-negative re clips to 131071; 131071 + 65535 = 196606 -> 65535
    clear_bins();
    re_v[3] = -131072;
    im_v[3] = 131071;
    set_bins();
    run_frame(0, 1'b0, -1);
    check("lit_sat_bar3",   dut_bar(3), 65535);
    check("model_sat_bar3", mbars[3],   65535);
    idle_gap(1'b0);

    clear_bins();
    re_v[5] = 800;
    set_bins();
    run_frame(4, 1'b0, -1);
    check("lit_bar5_800", dut_bar(5), 800);
    idle_gap(1'b0);

    clear_bins();
    set_bins();
    run_frame(2, 1'b0, -1);
`ifdef SPECTRUM_PEAK_DECAY_EN
    check("lit_decay_700",   dut_bar(5), 700);
    check("model_decay_700", mbars[5],   700);
`else
    check("lit_follow_0", dut_bar(5), 0);
`endif
    idle_gap(1'b0);

    run_frame(5, 1'b0, -1);
`ifdef SPECTRUM_PEAK_DECAY_EN
    check("lit_decay_613",   dut_bar(5), 613);
    check("model_decay_613", mbars[5],   613);
`else
    check("lit_follow_0b", dut_bar(5), 0);
`endif
    idle_gap(1'b0);

    re_v[5] = 900;
    set_bins();
    run_frame(TO - 1, 1'b0, -1);
    check("lit_bar5_900", dut_bar(5), 900);
    idle_gap(1'b0);

    // no fft_done at all: timeout, bars keep the previous frame
    for (int k = 0; k < NB; k++) begin
      re_v[k] = rnd_h();
      im_v[k] = rnd_h();
    end
    set_bins();
    run_frame(TO + 5, 1'b0, -1);
    check("lit_timeout",      bus.timeout_err, 1'b1);
    check("lit_timeout_bar5", dut_bar(5),      900);
    idle_gap(1'b1);

    repeat (30) begin
      for (int k = 0; k < NB; k++) begin
        re_v[k] = rnd_h();
        im_v[k] = rnd_h();
      end
      set_bins();
      run_frame(int'($urandom_range(0, TO + 2)), 1'($urandom_range(0, 1)), -1);
      idle_gap(1'b1);
    end

    for (int k = 0; k < NB; k++) begin
      re_v[k] = rnd_h() | 1;
      im_v[k] = rnd_h();
    end
    set_bins();
    run_frame(3, 1'b0, 7);
    check("lit_rst_bars",    bus.bars,        '0);
    check("lit_rst_timeout", bus.timeout_err, 1'b0);
    check("lit_rst_busy",    bus.busy,        1'b0);
    idle_gap(1'b0);

    repeat (10) begin
      for (int k = 0; k < NB; k++) begin
        re_v[k] = rnd_h();
        im_v[k] = rnd_h();
      end
      set_bins();
      run_frame(int'($urandom_range(0, TO + 2)), 1'($urandom_range(0, 1)), -1);
      idle_gap(1'b1);
    end

    tick();
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
